// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU and its program loader: halt encoding,
// instruction-memory size and the loader state encoding.
package cpu_pkg;

   localparam logic [15:0] HALT_WORD   = 16'hFFFF;
   localparam int          IMEM_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// Word counter for the program loader: clear, saturating increment,
// terminal-count flag and the matching byte address for the write port.
module loader_addr_counter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              incr,
   output logic [ADDR_W:0]   count,
   output logic [15:0]       byte_addr,
   output logic              terminal
);

   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   // Saturates at the memory depth so the count can never wrap back to 0
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (incr && (count != FULL)) begin
         count <= count + 1'b1;
      end
   end

   assign byte_addr = 16'({count[ADDR_W-1:0], 1'b0});
   assign terminal  = (count == LAST);

endmodule

// File: rtl/imem_loader.sv
// Fills the CPU instruction memory from a valid/ready word stream and keeps
// the CPU held until the halt word has been written.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int          ADDR_W    = IMEM_ADDR_W,
   parameter logic [15:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [15:0]       mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);

   loader_state_t state;
   logic          xfer;
   logic          restart;
   logic          terminal;
   logic [15:0]   byte_addr;

   assign in_ready = (state == LOAD);
   assign xfer     = in_valid && in_ready;
   assign restart  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

   loader_addr_counter #(
      .ADDR_W    (ADDR_W)
   ) u_counter (
      .clock     (clock),
      .reset     (reset),
      .clear     (restart),
      .incr      (xfer),
      .count     (word_count),
      .byte_addr (byte_addr),
      .terminal  (terminal)
   );

   // Reset wins over a pending transfer, so an aborted load never writes
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         mem_we <= xfer;
         if (xfer) begin
            mem_addr  <= byte_addr;
            mem_wdata <= in_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (in_data == HALT_WORD) begin
                     state <= FLUSH;
                  end else if (terminal) begin
                     state    <= ERROR;
                     overflow <= 1'b1;
                  end
               end
            end
            // One spare cycle lets the halt-word write land before release
            FLUSH: begin
               state    <= DONE;
               cpu_hold <= 1'b0;
               done     <= 1'b1;
            end
            DONE: begin
               if (start) begin
                  state    <= LOAD;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
               end
            end
            ERROR: begin
               if (start) begin
                  state    <= LOAD;
                  overflow <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a full-size instance for the normal
// load flows and a 4-word instance for the overflow boundary.
module tb_imem_loader;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, mem_we, cpu_hold, done, overflow;
   logic [15:0] mem_addr, mem_wdata;
   logic [10:0] word_count;

   logic        s_start = 1'b0;
   logic        s_valid = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_ready, s_we, s_hold, s_done, s_ovf;
   logic [15:0] s_addr, s_wdata;
   logic [2:0]  s_count;

   wr_t exp_q[$];
   wr_t exp_sq[$];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   imem_loader dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   imem_loader #(
      .ADDR_W     (2)
   ) dut_small (
      .clock      (clock),
      .reset      (reset),
      .start      (s_start),
      .in_valid   (s_valid),
      .in_data    (s_data),
      .in_ready   (s_ready),
      .mem_we     (s_we),
      .mem_addr   (s_addr),
      .mem_wdata  (s_wdata),
      .cpu_hold   (s_hold),
      .done       (s_done),
      .overflow   (s_ovf),
      .word_count (s_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Every write must match the oldest outstanding expectation, including its cycle
   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL big_unexpected_write: got addr=%h data=%h cyc=%0d, wanted no write", mem_addr, mem_wdata, cyc);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || mem_addr !== e.addr || mem_wdata !== e.data) begin
               n_bad++;
               $display("[TB] FAIL big_write: got cyc=%0d addr=%h data=%h, wanted cyc=%0d addr=%h data=%h", cyc, mem_addr, mem_wdata, e.cyc, e.addr, e.data);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (s_we === 1'b1) begin
         n_cmp++;
         if (exp_sq.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL small_unexpected_write: got addr=%h data=%h cyc=%0d, wanted no write", s_addr, s_wdata, cyc);
         end else begin
            wr_t e;
            e = exp_sq.pop_front();
            if (cyc != e.cyc || s_addr !== e.addr || s_wdata !== e.data) begin
               n_bad++;
               $display("[TB] FAIL small_write: got cyc=%0d addr=%h data=%h, wanted cyc=%0d addr=%h data=%h", cyc, s_addr, s_wdata, e.cyc, e.addr, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_word(input logic [15:0] w, input logic [15:0] a, input bit expect_wr);
      wr_t e;
      in_valid = 1'b1;
      in_data  = w;
      if (expect_wr) begin
         e.cyc  = cyc + 1;
         e.addr = a;
         e.data = w;
         exp_q.push_back(e);
      end
      tick();
   endtask

   task automatic drive_word_s(input logic [15:0] w, input logic [15:0] a, input bit expect_wr);
      wr_t e;
      s_valid = 1'b1;
      s_data  = w;
      if (expect_wr) begin
         e.cyc  = cyc + 1;
         e.addr = a;
         e.data = w;
         exp_sq.push_back(e);
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, overflow, word_count} !==
          {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd0}) begin
         n_bad++;
         $display("[TB] FAIL reset_state: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b ovf=%b wc=%0d, wanted 0 0 0000 0000 1 0 0 0",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, overflow, word_count);
      end
      reset = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      tick();
      tick();
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || word_count !== 11'd0) begin
         n_bad++;
         $display("[TB] FAIL idle_ignores_valid: got rdy=%b hold=%b wc=%0d, wanted 0 1 0", in_ready, cpu_hold, word_count);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_happy_path();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || word_count !== 11'd0) begin
         n_bad++;
         $display("[TB] FAIL happy_enter_load: got rdy=%b wc=%0d, wanted 1 0", in_ready, word_count);
      end
      drive_word(16'h710F, 16'h0000, 1'b1);
      drive_word(16'h7207, 16'h0002, 1'b1);
      drive_word(16'h26C0, 16'h0004, 1'b1);
      drive_word(16'hFFFF, 16'h0006, 1'b1);
      in_data = 16'hBEEF;
      n_cmp++;
      if (in_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || word_count !== 11'd4) begin
         n_bad++;
         $display("[TB] FAIL happy_flush: got rdy=%b done=%b hold=%b wc=%0d, wanted 0 0 1 4", in_ready, done, cpu_hold, word_count);
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 11'd4 || in_ready !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL happy_release: got done=%b hold=%b wc=%0d rdy=%b, wanted 1 0 4 0", done, cpu_hold, word_count, in_ready);
      end
      tick();
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL happy_missing_writes: got %0d outstanding, wanted 0", exp_q.size());
      end
   endtask

   task automatic test_reload();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 11'd0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL reload_start: got hold=%b done=%b wc=%0d rdy=%b, wanted 1 0 0 1", cpu_hold, done, word_count, in_ready);
      end
      drive_word(16'h1111, 16'h0000, 1'b1);
      drive_word(16'hFFFF, 16'h0002, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (done !== 1'b1 || word_count !== 11'd2 || exp_q.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL reload_finish: got done=%b wc=%0d outstanding=%0d, wanted 1 2 0", done, word_count, exp_q.size());
      end
   endtask

   task automatic test_stalled();
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_word(16'hA5A5, 16'h0000, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      drive_word(16'h5A5A, 16'h0002, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (word_count !== 11'd2 || exp_q.size() != 0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL stalled_count: got wc=%0d outstanding=%0d rdy=%b, wanted 2 0 1", word_count, exp_q.size(), in_ready);
      end
      drive_word(16'hFFFF, 16'h0004, 1'b1);
      in_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      drive_word(16'h0A0A, 16'h0000, 1'b1);
      drive_word(16'h0B0B, 16'h0002, 1'b1);
      reset = 1'b1;
      drive_word(16'h0C0C, 16'h0004, 1'b0);
      reset = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if ({in_ready, mem_we, cpu_hold, done, overflow, word_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
         n_bad++;
         $display("[TB] FAIL reset_mid_load: got rdy=%b we=%b hold=%b done=%b ovf=%b wc=%0d, wanted 0 0 1 0 0 0",
                  in_ready, mem_we, cpu_hold, done, overflow, word_count);
      end
      tick();
      tick();
      n_cmp++;
      if (exp_q.size() != 0 || in_ready !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_mid_idle: got outstanding=%0d rdy=%b, wanted 0 0", exp_q.size(), in_ready);
      end
   endtask

   task automatic test_overflow();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      drive_word_s(16'h0101, 16'h0000, 1'b1);
      drive_word_s(16'h0202, 16'h0002, 1'b1);
      drive_word_s(16'h0303, 16'h0004, 1'b1);
      drive_word_s(16'h0404, 16'h0006, 1'b1);
      s_data = 16'h0505;
      n_cmp++;
      if (s_ovf !== 1'b1 || s_hold !== 1'b1 || s_ready !== 1'b0 || s_done !== 1'b0 || s_count !== 3'd4) begin
         n_bad++;
         $display("[TB] FAIL overflow_flag: got ovf=%b hold=%b rdy=%b done=%b wc=%0d, wanted 1 1 0 0 4", s_ovf, s_hold, s_ready, s_done, s_count);
      end
      tick();
      tick();
      s_valid = 1'b0;
      n_cmp++;
      if (s_count !== 3'd4 || s_ready !== 1'b0 || exp_sq.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL overflow_fifth: got wc=%0d rdy=%b outstanding=%0d, wanted 4 0 0", s_count, s_ready, exp_sq.size());
      end
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      n_cmp++;
      if (s_ovf !== 1'b0 || s_count !== 3'd0 || s_ready !== 1'b1 || s_hold !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL overflow_restart: got ovf=%b wc=%0d rdy=%b hold=%b, wanted 0 0 1 1", s_ovf, s_count, s_ready, s_hold);
      end
      drive_word_s(16'h0606, 16'h0000, 1'b1);
      drive_word_s(16'h0707, 16'h0002, 1'b1);
      drive_word_s(16'h0808, 16'h0004, 1'b1);
      drive_word_s(16'hFFFF, 16'h0006, 1'b1);
      s_valid = 1'b0;
      tick();
      n_cmp++;
      if (s_done !== 1'b1 || s_ovf !== 1'b0 || s_hold !== 1'b0 || s_count !== 3'd4 || exp_sq.size() != 0) begin
         n_bad++;
         $display("[TB] FAIL halt_in_last_slot: got done=%b ovf=%b hold=%b wc=%0d outstanding=%0d, wanted 1 0 0 4 0",
                  s_done, s_ovf, s_hold, s_count, exp_sq.size());
      end
   endtask

   initial begin
      test_reset();
      test_happy_path();
      test_reload();
      test_stalled();
      test_reset_mid_load();
      test_overflow();
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
